// File: rtl/rs_param.sv
// rtl/rs_param.sv - two-pool reservation station with dual CDB wakeup and age-ordered issue
// rs_pool holds one instruction class; rs_param resolves dispatch bypass and routes to a pool.

module rs_pool #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3,
    parameter int OP_W   = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             acc,
    input  logic [OP_W-1:0]                  in_op,
    input  logic [DATA_W-1:0]                in_value1,
    input  logic [DATA_W-1:0]                in_value2,
    input  logic [TAG_W-1:0]                 in_query1,
    input  logic [TAG_W-1:0]                 in_query2,
    input  logic [TAG_W-1:0]                 in_des,
    input  logic                             cdb0_valid,
    input  logic [TAG_W-1:0]                 cdb0_tag,
    input  logic [DATA_W-1:0]                cdb0_data,
    input  logic                             cdb1_valid,
    input  logic [TAG_W-1:0]                 cdb1_tag,
    input  logic [DATA_W-1:0]                cdb1_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OP_W-1:0]                  out_op,
    output logic [DATA_W-1:0]                out_value1,
    output logic [DATA_W-1:0]                out_value2,
    output logic [TAG_W-1:0]                 out_des,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(DEPTH);

    logic              busy   [DEPTH];
    logic [OP_W-1:0]   op     [DEPTH];
    logic [DATA_W-1:0] value1 [DEPTH];
    logic [DATA_W-1:0] value2 [DEPTH];
    logic [TAG_W-1:0]  query1 [DEPTH];
    logic [TAG_W-1:0]  query2 [DEPTH];
    logic [TAG_W-1:0]  des    [DEPTH];
    logic [RW-1:0]     rank   [DEPTH];

    logic          any_ready;
    logic [RW-1:0] sel;
    logic [RW-1:0] sel_rank;
    logic [RW-1:0] free_idx;
    logic          free_found;
    logic          can_issue;
    logic          issue;
    logic [RW-1:0] new_rank;

    // Ranks are unique, so the minimum-rank ready entry is the oldest ready one.
    always_comb begin
        any_ready  = 1'b0;
        sel        = '0;
        sel_rank   = '0;
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && query1[i] == '0 && query2[i] == '0 &&
                (!any_ready || rank[i] < sel_rank)) begin
                any_ready = 1'b1;
                sel       = RW'(i);
                sel_rank  = rank[i];
            end
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = RW'(i);
            end
        end
    end

    assign can_issue = !out_valid || out_ready;
    assign issue     = can_issue && any_ready;
    assign new_rank  = RW'(count - CW'(issue));
    assign full      = (count == CW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy[i]   <= 1'b0;
                op[i]     <= '0;
                value1[i] <= '0;
                value2[i] <= '0;
                query1[i] <= '0;
                query2[i] <= '0;
                des[i]    <= '0;
                rank[i]   <= '0;
            end
            out_valid  <= 1'b0;
            out_op     <= '0;
            out_value1 <= '0;
            out_value2 <= '0;
            out_des    <= '0;
            count      <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy[i] <= 1'b0;
            end
            out_valid <= 1'b0;
            count     <= '0;
        end else begin
            if (can_issue) begin
                out_valid <= any_ready;
                if (any_ready) begin
                    out_op     <= op[sel];
                    out_value1 <= value1[sel];
                    out_value2 <= value2[sel];
                    out_des    <= des[sel];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i]) begin
                    if (issue && sel == RW'(i)) begin
                        busy[i] <= 1'b0;
                    end else if (issue && rank[i] > sel_rank) begin
                        rank[i] <= rank[i] - 1'b1;
                    end
                    // cdb0 is tested first so it wins when both ports carry the same tag.
                    if (cdb0_valid && cdb0_tag != '0 && query1[i] == cdb0_tag) begin
                        value1[i] <= cdb0_data;
                        query1[i] <= '0;
                    end else if (cdb1_valid && cdb1_tag != '0 && query1[i] == cdb1_tag) begin
                        value1[i] <= cdb1_data;
                        query1[i] <= '0;
                    end
                    if (cdb0_valid && cdb0_tag != '0 && query2[i] == cdb0_tag) begin
                        value2[i] <= cdb0_data;
                        query2[i] <= '0;
                    end else if (cdb1_valid && cdb1_tag != '0 && query2[i] == cdb1_tag) begin
                        value2[i] <= cdb1_data;
                        query2[i] <= '0;
                    end
                end else if (acc && free_idx == RW'(i)) begin
                    busy[i]   <= 1'b1;
                    op[i]     <= in_op;
                    value1[i] <= in_value1;
                    value2[i] <= in_value2;
                    query1[i] <= in_query1;
                    query2[i] <= in_query2;
                    des[i]    <= in_des;
                    rank[i]   <= new_rank;
                end
            end
            count <= count + CW'(acc) - CW'(issue);
        end
    end
endmodule

module rs_param #(
    parameter int ALU_DEPTH = 3,
    parameter int MEM_DEPTH = 3,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 3,
    parameter int OP_W      = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_is_mem,
    input  logic [OP_W-1:0]                  in_op,
    input  logic [DATA_W-1:0]                in_value1,
    input  logic [DATA_W-1:0]                in_value2,
    input  logic [TAG_W-1:0]                 in_query1,
    input  logic [TAG_W-1:0]                 in_query2,
    input  logic [TAG_W-1:0]                 in_des,
    input  logic                             cdb0_valid,
    input  logic [TAG_W-1:0]                 cdb0_tag,
    input  logic [DATA_W-1:0]                cdb0_data,
    input  logic                             cdb1_valid,
    input  logic [TAG_W-1:0]                 cdb1_tag,
    input  logic [DATA_W-1:0]                cdb1_data,
    output logic                             alu_valid,
    input  logic                             alu_ready,
    output logic [OP_W-1:0]                  alu_op,
    output logic [DATA_W-1:0]                alu_value1,
    output logic [DATA_W-1:0]                alu_value2,
    output logic [TAG_W-1:0]                 alu_des,
    output logic                             mem_valid,
    input  logic                             mem_ready,
    output logic [OP_W-1:0]                  mem_op,
    output logic [DATA_W-1:0]                mem_value1,
    output logic [DATA_W-1:0]                mem_value2,
    output logic [TAG_W-1:0]                 mem_des,
    output logic [$clog2(ALU_DEPTH+1)-1:0]   alu_count,
    output logic [$clog2(MEM_DEPTH+1)-1:0]   mem_count,
    output logic                             alu_full,
    output logic                             mem_full
);
    logic [DATA_W-1:0] byp_value1;
    logic [DATA_W-1:0] byp_value2;
    logic [TAG_W-1:0]  byp_query1;
    logic [TAG_W-1:0]  byp_query2;
    logic              acc_alu;
    logic              acc_mem;

    // Operands broadcast in the dispatch cycle are captured here, otherwise they would be missed.
    always_comb begin
        byp_value1 = in_value1;
        byp_query1 = in_query1;
        byp_value2 = in_value2;
        byp_query2 = in_query2;
        if (in_query1 != '0) begin
            if (cdb0_valid && cdb0_tag == in_query1) begin
                byp_value1 = cdb0_data;
                byp_query1 = '0;
            end else if (cdb1_valid && cdb1_tag == in_query1) begin
                byp_value1 = cdb1_data;
                byp_query1 = '0;
            end
        end
        if (in_query2 != '0) begin
            if (cdb0_valid && cdb0_tag == in_query2) begin
                byp_value2 = cdb0_data;
                byp_query2 = '0;
            end else if (cdb1_valid && cdb1_tag == in_query2) begin
                byp_value2 = cdb1_data;
                byp_query2 = '0;
            end
        end
    end

    assign in_ready = !flush && !(in_is_mem ? mem_full : alu_full);
    assign acc_alu  = in_valid && in_ready && !in_is_mem;
    assign acc_mem  = in_valid && in_ready && in_is_mem;

    rs_pool #(.DEPTH(ALU_DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) u_alu (
        .clk(clk), .rst(rst), .flush(flush), .acc(acc_alu),
        .in_op(in_op), .in_value1(byp_value1), .in_value2(byp_value2),
        .in_query1(byp_query1), .in_query2(byp_query2), .in_des(in_des),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .out_valid(alu_valid), .out_ready(alu_ready), .out_op(alu_op),
        .out_value1(alu_value1), .out_value2(alu_value2), .out_des(alu_des),
        .count(alu_count), .full(alu_full)
    );

    rs_pool #(.DEPTH(MEM_DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) u_mem (
        .clk(clk), .rst(rst), .flush(flush), .acc(acc_mem),
        .in_op(in_op), .in_value1(byp_value1), .in_value2(byp_value2),
        .in_query1(byp_query1), .in_query2(byp_query2), .in_des(in_des),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .out_valid(mem_valid), .out_ready(mem_ready), .out_op(mem_op),
        .out_value1(mem_value1), .out_value2(mem_value2), .out_des(mem_des),
        .count(mem_count), .full(mem_full)
    );
endmodule

// File: tb/tb_rs_param.sv
// tb/tb_rs_param.sv - scoreboard bench for rs_param
// Issued beats are checked against queued expectations on every completed handshake.

module tb_rs_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_mem = 1'b0;
    logic [5:0]  in_op = '0;
    logic [31:0] in_value1 = '0;
    logic [31:0] in_value2 = '0;
    logic [2:0]  in_query1 = '0;
    logic [2:0]  in_query2 = '0;
    logic [2:0]  in_des = '0;
    logic        cdb0_valid = 1'b0;
    logic [2:0]  cdb0_tag = '0;
    logic [31:0] cdb0_data = '0;
    logic        cdb1_valid = 1'b0;
    logic [2:0]  cdb1_tag = '0;
    logic [31:0] cdb1_data = '0;
    logic        alu_valid;
    logic        alu_ready = 1'b1;
    logic [5:0]  alu_op;
    logic [31:0] alu_value1;
    logic [31:0] alu_value2;
    logic [2:0]  alu_des;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [5:0]  mem_op;
    logic [31:0] mem_value1;
    logic [31:0] mem_value2;
    logic [2:0]  mem_des;
    logic [1:0]  alu_count;
    logic [1:0]  mem_count;
    logic        alu_full;
    logic        mem_full;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [2:0]  des;
    } beat_t;

    beat_t alu_q[$];
    beat_t mem_q[$];
    int    tests = 0;
    int    fails = 0;

    rs_param dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem),
        .in_op(in_op), .in_value1(in_value1), .in_value2(in_value2),
        .in_query1(in_query1), .in_query2(in_query2), .in_des(in_des),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_value1(alu_value1), .alu_value2(alu_value2), .alu_des(alu_des),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_op(mem_op),
        .mem_value1(mem_value1), .mem_value2(mem_value2), .mem_des(mem_des),
        .alu_count(alu_count), .mem_count(mem_count),
        .alu_full(alu_full), .mem_full(mem_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic m, input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [2:0] q1, input logic [2:0] q2, input logic [2:0] d);
        in_valid  = 1'b1;
        in_is_mem = m;
        in_op     = op;
        in_value1 = v1;
        in_value2 = v2;
        in_query1 = q1;
        in_query2 = q2;
        in_des    = d;
        step();
        in_valid  = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && alu_valid && alu_ready) begin
            tests++;
            if (alu_q.size() == 0) begin
                fails++;
                $display("FAIL alu_unexpected: got op=%0h v1=%0h v2=%0h des=%0h, none expected",
                         alu_op, alu_value1, alu_value2, alu_des);
            end else begin
                e = alu_q.pop_front();
                if ({alu_op, alu_value1, alu_value2, alu_des} !== e) begin
                    fails++;
                    $display("FAIL alu_beat: got op=%0h v1=%0h v2=%0h des=%0h expected op=%0h v1=%0h v2=%0h des=%0h",
                             alu_op, alu_value1, alu_value2, alu_des, e.op, e.v1, e.v2, e.des);
                end
            end
        end
        if (!rst && mem_valid && mem_ready) begin
            tests++;
            if (mem_q.size() == 0) begin
                fails++;
                $display("FAIL mem_unexpected: got op=%0h v1=%0h v2=%0h des=%0h, none expected",
                         mem_op, mem_value1, mem_value2, mem_des);
            end else begin
                e = mem_q.pop_front();
                if ({mem_op, mem_value1, mem_value2, mem_des} !== e) begin
                    fails++;
                    $display("FAIL mem_beat: got op=%0h v1=%0h v2=%0h des=%0h expected op=%0h v1=%0h v2=%0h des=%0h",
                             mem_op, mem_value1, mem_value2, mem_des, e.op, e.v1, e.v2, e.des);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_alu_count", alu_count, 0);
        chk("rst_mem_count", mem_count, 0);
        chk("rst_alu_full", alu_full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_value1", alu_value1, 0);
        step();
        rst = 1'b0;
        step();

        // Minimum-latency dispatch to issue
        alu_q.push_back('{op: 6'h0, v1: 32'd5, v2: 32'd7, des: 3'd2});
        disp(1'b0, 6'h0, 32'd5, 32'd7, 3'd0, 3'd0, 3'd2);
        chk("lat_count_after_accept", alu_count, 1);
        chk("lat_valid_early", alu_valid, 0);
        step();
        chk("lat_valid", alu_valid, 1);
        chk("lat_count_after_issue", alu_count, 0);
        step();
        chk("lat_valid_drop", alu_valid, 0);

        // Fill ALU pool waiting on tag 4, release with cdb0
        for (int i = 1; i <= 3; i++) begin
            alu_q.push_back('{op: 6'(i), v1: 32'h99, v2: 32'h10 + 32'(i), des: 3'(i)});
            disp(1'b0, 6'(i), 32'h0, 32'h10 + 32'(i), 3'd4, 3'd0, 3'(i));
        end
        chk("fill_alu_full", alu_full, 1);
        chk("fill_alu_count", alu_count, 3);
        in_valid  = 1'b1;
        in_is_mem = 1'b0;
        #1;
        chk("fill_in_ready_alu", in_ready, 0);
        in_is_mem = 1'b1;
        #1;
        chk("fill_in_ready_mem", in_ready, 1);
        in_valid = 1'b0;
        step();
        chk("fill_no_issue", alu_valid, 0);
        cdb0_valid = 1'b1; cdb0_tag = 3'd4; cdb0_data = 32'h99;
        step();
        cdb0_valid = 1'b0;
        repeat (4) step();
        chk("fill_drain_valid", alu_valid, 0);
        chk("fill_drain_count", alu_count, 0);
        chk("fill_drain_full", alu_full, 0);

        // Dispatch bypass from cdb1
        alu_q.push_back('{op: 6'h4, v1: 32'h21, v2: 32'h1234, des: 3'd5});
        cdb1_valid = 1'b1; cdb1_tag = 3'd5; cdb1_data = 32'h1234;
        disp(1'b0, 6'h4, 32'h21, 32'hdead, 3'd0, 3'd5, 3'd5);
        cdb1_valid = 1'b0;
        step();
        chk("byp_valid", alu_valid, 1);
        step();

        // Memory pool age ordering
        mem_q.push_back('{op: 6'h12, v1: 32'hC1, v2: 32'hC2, des: 3'd3});
        mem_q.push_back('{op: 6'h10, v1: 32'h66, v2: 32'hA2, des: 3'd1});
        mem_q.push_back('{op: 6'h11, v1: 32'h77, v2: 32'hB2, des: 3'd2});
        disp(1'b1, 6'h10, 32'h0, 32'hA2, 3'd6, 3'd0, 3'd1);
        disp(1'b1, 6'h11, 32'h0, 32'hB2, 3'd7, 3'd0, 3'd2);
        disp(1'b1, 6'h12, 32'hC1, 32'hC2, 3'd0, 3'd0, 3'd3);
        cdb0_valid = 1'b1; cdb0_tag = 3'd7; cdb0_data = 32'h77;
        cdb1_valid = 1'b1; cdb1_tag = 3'd6; cdb1_data = 32'h66;
        step();
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
        repeat (3) step();
        chk("age_mem_count", mem_count, 0);

        // Backpressure holds the output stable
        mem_ready = 1'b0;
        mem_q.push_back('{op: 6'h20, v1: 32'hD1, v2: 32'hD2, des: 3'd4});
        mem_q.push_back('{op: 6'h21, v1: 32'hE1, v2: 32'hE2, des: 3'd5});
        disp(1'b1, 6'h20, 32'hD1, 32'hD2, 3'd0, 3'd0, 3'd4);
        disp(1'b1, 6'h21, 32'hE1, 32'hE2, 3'd0, 3'd0, 3'd5);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", mem_valid, 1);
            chk("stall_value1", mem_value1, 32'hD1);
            chk("stall_op", mem_op, 32'h20);
            step();
        end
        chk("stall_count", mem_count, 1);
        mem_ready = 1'b1;
        repeat (3) step();

        // Both CDBs carry the same tag: cdb0 wins
        alu_q.push_back('{op: 6'h5, v1: 32'hA, v2: 32'h55, des: 3'd6});
        disp(1'b0, 6'h5, 32'h0, 32'h55, 3'd3, 3'd0, 3'd6);
        cdb0_valid = 1'b1; cdb0_tag = 3'd3; cdb0_data = 32'hA;
        cdb1_valid = 1'b1; cdb1_tag = 3'd3; cdb1_data = 32'hB;
        step();
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
        repeat (3) step();

        // Flush with pending output and concurrent dispatch
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        disp(1'b0, 6'h30, 32'h1, 32'h2, 3'd7, 3'd0, 3'd1);
        disp(1'b1, 6'h31, 32'h3, 32'h4, 3'd0, 3'd0, 3'd2);
        disp(1'b1, 6'h32, 32'h5, 32'h6, 3'd0, 3'd6, 3'd3);
        chk("pre_flush_mem_valid", mem_valid, 1);
        chk("pre_flush_alu_count", alu_count, 1);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_is_mem = 1'b0;
        in_query1 = 3'd0;
        in_query2 = 3'd0;
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_alu_count", alu_count, 0);
        chk("flush_mem_count", mem_count, 0);
        chk("flush_alu_valid", alu_valid, 0);
        chk("flush_mem_valid", mem_valid, 0);
        step();
        chk("flush_dropped_valid", alu_valid, 0);
        chk("flush_dropped_count", alu_count, 0);
        alu_ready = 1'b1;
        mem_ready = 1'b1;
        repeat (2) step();

        // Asynchronous reset mid-cycle
        alu_ready = 1'b0;
        disp(1'b0, 6'h3F, 32'h5A, 32'h5B, 3'd0, 3'd0, 3'd7);
        disp(1'b1, 6'h3E, 32'h1, 32'h2, 3'd2, 3'd0, 3'd1);
        step();
        chk("pre_rst_alu_valid", alu_valid, 1);
        chk("pre_rst_mem_count", mem_count, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_alu_valid", alu_valid, 0);
        chk("async_rst_alu_value1", alu_value1, 0);
        chk("async_rst_mem_count", mem_count, 0);
        chk("async_rst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        alu_ready = 1'b1;
        repeat (2) step();

        chk("alu_queue_empty", alu_q.size(), 0);
        chk("mem_queue_empty", mem_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
